// File: rtl/mpu_fetch_unit_if.sv
// Fetch-unit bus bundle: byte-wide program-memory request port and the
// instruction hand-off port toward decode.
interface mpu_fetch_unit_if;
  logic        mem_req_o;
  logic [11:0] mem_addr_o;
  logic        mem_ack_i;
  logic [7:0]  mem_data_i;

  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [7:0]  instr_opcode_o;
  logic [7:0]  instr_op1_o;
  logic [7:0]  instr_op2_o;
  logic [7:0]  instr_op3_o;
  logic [1:0]  instr_nops_o;
  logic [11:0] instr_pc_o;

  modport master (
    output mem_req_o, mem_addr_o,
    input  mem_ack_i, mem_data_i,
    output instr_valid_o, instr_opcode_o, instr_op1_o, instr_op2_o,
           instr_op3_o, instr_nops_o, instr_pc_o,
    input  instr_ready_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o,
    output mem_ack_i, mem_data_i,
    input  instr_valid_o, instr_opcode_o, instr_op1_o, instr_op2_o,
           instr_op3_o, instr_nops_o, instr_pc_o,
    output instr_ready_i
  );
endinterface

// File: rtl/mpu_fetch_unit.sv
// Byte-serial instruction fetch: gathers opcode plus 0-3 operand bytes from
// program memory and presents the complete instruction to decode.
module mpu_fetch_unit #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt_i,
  input  logic              pc_load_i,
  input  logic [11:0]       pc_load_addr_i,
  mpu_fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {FETCH_OPC, FETCH_OPND, PRESENT, HALTED} state_t;

  state_t           state_q, state_d, ret_q, ret_d, fetch_nxt, byte_nxt;
  logic             run_q;
  logic [11:0]      pc_q, pc_tgt;
  logic             redir_q;
  logic [11:0]      redir_addr_q;
  logic [7:0]       opc_q;
  logic [2:0][7:0]  ops_q;
  logic [1:0]       nops_q, idx_q;
  logic [11:0]      ipc_q;

  logic fetching, mem_req, accept;
  logic pc_ld, pc_inc, cap_opc, cap_opnd, clr_ops, redir_set, redir_clr;

  // run_q keeps the request low until the first edge after reset release
  assign fetching = (state_q == FETCH_OPC) || (state_q == FETCH_OPND);
  assign mem_req  = fetching && run_q;
  assign accept   = mem_req && bus.mem_ack_i;

  always_comb begin
    byte_nxt = FETCH_OPND;
    if (state_q == FETCH_OPC) begin
      if (bus.mem_data_i[6:5] == 2'd0) byte_nxt = PRESENT;
    end else if ((idx_q + 2'd1) == nops_q) begin
      byte_nxt = PRESENT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH_OPC;
      ret_q   <= FETCH_OPC;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    fetch_nxt = FETCH_OPC;
    pc_ld     = 1'b0;
    pc_tgt    = pc_load_addr_i;
    pc_inc    = 1'b0;
    cap_opc   = 1'b0;
    cap_opnd  = 1'b0;
    clr_ops   = 1'b0;
    redir_set = 1'b0;
    redir_clr = 1'b0;
    case (state_q)
      FETCH_OPC, FETCH_OPND: begin
        if (accept) begin
          // a pending or same-cycle redirect turns this byte into a discard
          if (pc_load_i || redir_q) begin
            pc_ld     = 1'b1;
            pc_tgt    = pc_load_i ? pc_load_addr_i : redir_addr_q;
            clr_ops   = 1'b1;
            redir_clr = 1'b1;
            fetch_nxt = FETCH_OPC;
          end else begin
            pc_inc    = 1'b1;
            cap_opc   = (state_q == FETCH_OPC);
            cap_opnd  = (state_q == FETCH_OPND);
            fetch_nxt = byte_nxt;
          end
          if (halt_i) begin
            state_d = HALTED;
            ret_d   = fetch_nxt;
          end else begin
            state_d = fetch_nxt;
          end
        end else if (mem_req) begin
          // request outstanding: address must stay put until acked
          if (pc_load_i) redir_set = 1'b1;
        end else begin
          if (pc_load_i) begin
            pc_ld   = 1'b1;
            clr_ops = 1'b1;
            state_d = FETCH_OPC;
          end
          if (halt_i) begin
            state_d = HALTED;
            ret_d   = FETCH_OPC;
          end
        end
      end
      PRESENT: begin
        if (pc_load_i || bus.instr_ready_i) begin
          pc_ld   = pc_load_i;
          clr_ops = 1'b1;
          if (halt_i) begin
            state_d = HALTED;
            ret_d   = FETCH_OPC;
          end else begin
            state_d = FETCH_OPC;
          end
        end else if (halt_i) begin
          state_d = HALTED;
          ret_d   = PRESENT;
        end
      end
      HALTED: begin
        if (pc_load_i) begin
          pc_ld   = 1'b1;
          clr_ops = 1'b1;
          ret_d   = FETCH_OPC;
        end
        if (!halt_i) state_d = pc_load_i ? FETCH_OPC : ret_q;
      end
      default: state_d = FETCH_OPC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q        <= 1'b0;
      pc_q         <= RESET_PC;
      redir_q      <= 1'b0;
      redir_addr_q <= '0;
      opc_q        <= '0;
      ops_q        <= '0;
      nops_q       <= '0;
      idx_q        <= '0;
      ipc_q        <= '0;
    end else begin
      run_q <= 1'b1;
      if (pc_ld)       pc_q <= pc_tgt;
      else if (pc_inc) pc_q <= pc_q + 12'd1;
      if (redir_set) begin
        redir_q      <= 1'b1;
        redir_addr_q <= pc_load_addr_i;
      end else if (redir_clr) begin
        redir_q      <= 1'b0;
      end
      if (cap_opc) begin
        opc_q  <= bus.mem_data_i;
        nops_q <= bus.mem_data_i[6:5];
        ipc_q  <= pc_q;
        ops_q  <= '0;
        idx_q  <= '0;
      end
      if (cap_opnd) begin
        ops_q[idx_q] <= bus.mem_data_i;
        idx_q        <= idx_q + 2'd1;
      end
      if (clr_ops) begin
        ops_q <= '0;
        idx_q <= '0;
      end
    end
  end

  assign bus.mem_req_o      = mem_req;
  assign bus.mem_addr_o     = pc_q;
  assign bus.instr_valid_o  = (state_q == PRESENT);
  assign bus.instr_opcode_o = opc_q;
  assign bus.instr_op1_o    = ops_q[0];
  assign bus.instr_op2_o    = ops_q[1];
  assign bus.instr_op3_o    = ops_q[2];
  assign bus.instr_nops_o   = nops_q;
  assign bus.instr_pc_o     = ipc_q;

  // an unacked request is never withdrawn or moved
  a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (mem_req && !bus.mem_ack_i) |=> (mem_req && $stable(pc_q)));

  // a presented instruction stays put until consumed, redirected or halted
  a_present_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.instr_valid_o && !bus.instr_ready_i && !pc_load_i && !halt_i)
      |=> (bus.instr_valid_o && $stable(opc_q) && $stable(ops_q) && $stable(ipc_q)));

endmodule

// File: tb/tb_mpu_fetch_unit.sv
// Directed bench for mpu_fetch_unit: byte-returning memory image plus
// hand-computed expectations for each fetch scenario.
module tb_mpu_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        halt_i = 1'b0;
  logic        pc_load_i = 1'b0;
  logic [11:0] pc_load_addr_i = '0;
  logic        ack_en = 1'b0;
  logic        ready = 1'b0;
  logic [7:0]  mem_img [4096];
  int          n_chk = 0;
  int          n_err = 0;

  mpu_fetch_unit_if bus ();

  assign bus.mem_ack_i     = ack_en;
  assign bus.mem_data_i    = mem_img[bus.mem_addr_o];
  assign bus.instr_ready_i = ready;

  mpu_fetch_unit #(.RESET_PC(12'h000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .halt_i         (halt_i),
    .pc_load_i      (pc_load_i),
    .pc_load_addr_i (pc_load_addr_i),
    .bus            (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_req(input string tag, input logic [11:0] addr);
    chk({tag, "_req"}, {31'd0, bus.mem_req_o}, 32'd1);
    chk({tag, "_addr"}, {20'd0, bus.mem_addr_o}, {20'd0, addr});
  endtask

  task automatic chk_instr(input string tag, input logic [7:0] opc, input logic [1:0] nops,
                           input logic [7:0] o1, input logic [7:0] o2, input logic [7:0] o3,
                           input logic [11:0] ipc);
    chk({tag, "_valid"}, {31'd0, bus.instr_valid_o}, 32'd1);
    chk({tag, "_req_low"}, {31'd0, bus.mem_req_o}, 32'd0);
    chk({tag, "_opc"}, {24'd0, bus.instr_opcode_o}, {24'd0, opc});
    chk({tag, "_nops"}, {30'd0, bus.instr_nops_o}, {30'd0, nops});
    chk({tag, "_op1"}, {24'd0, bus.instr_op1_o}, {24'd0, o1});
    chk({tag, "_op2"}, {24'd0, bus.instr_op2_o}, {24'd0, o2});
    chk({tag, "_op3"}, {24'd0, bus.instr_op3_o}, {24'd0, o3});
    chk({tag, "_pc"}, {20'd0, bus.instr_pc_o}, {20'd0, ipc});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem_img[i] = 8'h00;
    mem_img[12'h000] = 8'h60; mem_img[12'h001] = 8'h11;
    mem_img[12'h002] = 8'h22; mem_img[12'h003] = 8'h33;
    mem_img[12'h004] = 8'h05; mem_img[12'h005] = 8'h60;
    mem_img[12'hFFE] = 8'h20; mem_img[12'hFFF] = 8'hAB;
    mem_img[12'h010] = 8'h20; mem_img[12'h011] = 8'h44;
    mem_img[12'h012] = 8'h60; mem_img[12'h013] = 8'h77;
    mem_img[12'h123] = 8'h40; mem_img[12'h124] = 8'h55; mem_img[12'h125] = 8'h66;

    // reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req", {31'd0, bus.mem_req_o}, 32'd0);
    chk("rst_valid", {31'd0, bus.instr_valid_o}, 32'd0);
    chk("rst_opc", {24'd0, bus.instr_opcode_o}, 32'd0);
    chk("rst_nops", {30'd0, bus.instr_nops_o}, 32'd0);
    chk("rst_ipc", {20'd0, bus.instr_pc_o}, 32'd0);
    tick();
    tick();
    rst_n  = 1'b1;
    ack_en = 1'b1;
    tick();

    // four back-to-back bytes: opcode 60 with three operands
    for (int i = 0; i < 4; i++) begin
      chk_req("b2b", 12'(i));
      tick();
    end
    chk_instr("i60", 8'h60, 2'd3, 8'h11, 8'h22, 8'h33, 12'h000);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("hs_valid_low", {31'd0, bus.instr_valid_o}, 32'd0);
    chk("hs_op1_clr", {24'd0, bus.instr_op1_o}, 32'd0);
    chk_req("opc004", 12'h004);

    // zero-operand opcode, decode stalls for five cycles
    tick();
    chk_instr("i05", 8'h05, 2'd0, 8'h00, 8'h00, 8'h00, 12'h004);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_instr("i05_stall", 8'h05, 2'd0, 8'h00, 8'h00, 8'h00, 12'h004);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("i05_done", {31'd0, bus.instr_valid_o}, 32'd0);
    chk_req("opc005", 12'h005);

    // redirect while the request is outstanding: byte at 005 dropped
    ack_en         = 1'b0;
    pc_load_i      = 1'b1;
    pc_load_addr_i = 12'hFFE;
    tick();
    pc_load_i = 1'b0;
    chk_req("redir_hold", 12'h005);
    ack_en = 1'b1;
    tick();
    chk_req("redir_ffe", 12'hFFE);
    chk("redir_valid", {31'd0, bus.instr_valid_o}, 32'd0);

    // wrap across the top of the address space
    tick();
    chk_req("wrap_fff", 12'hFFF);
    tick();
    chk_instr("i20", 8'h20, 2'd1, 8'hAB, 8'h00, 8'h00, 12'hFFE);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk_req("wrap_000", 12'h000);

    // move to 010, then halt while that request waits for its ack
    ack_en         = 1'b0;
    pc_load_i      = 1'b1;
    pc_load_addr_i = 12'h010;
    tick();
    pc_load_i = 1'b0;
    ack_en    = 1'b1;
    tick();
    ack_en = 1'b0;
    halt_i = 1'b1;
    chk_req("halt_pre", 12'h010);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_req("halt_wait", 12'h010);
    end
    ack_en = 1'b1;
    tick();
    chk("halted_req", {31'd0, bus.mem_req_o}, 32'd0);
    chk("halted_valid", {31'd0, bus.instr_valid_o}, 32'd0);
    tick();
    chk("halted_req2", {31'd0, bus.mem_req_o}, 32'd0);
    chk("halted_pc", {20'd0, bus.mem_addr_o}, 32'h011);
    halt_i = 1'b0;
    tick();
    chk_req("resume", 12'h011);
    tick();
    chk_instr("i20b", 8'h20, 2'd1, 8'h44, 8'h00, 8'h00, 12'h010);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk_req("opc012", 12'h012);

    // redirect during operand fetch drops the partial instruction
    tick();
    chk_req("opnd013", 12'h013);
    pc_load_i      = 1'b1;
    pc_load_addr_i = 12'h123;
    tick();
    pc_load_i = 1'b0;
    chk_req("jmp123", 12'h123);
    chk("jmp_valid", {31'd0, bus.instr_valid_o}, 32'd0);
    chk("jmp_op1", {24'd0, bus.instr_op1_o}, 32'd0);
    tick();
    chk_req("opnd124", 12'h124);
    tick();
    chk_req("opnd125", 12'h125);
    chk("opnd_valid", {31'd0, bus.instr_valid_o}, 32'd0);

    // asynchronous reset in the middle of operand fetch
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, bus.mem_req_o}, 32'd0);
    chk("arst_valid", {31'd0, bus.instr_valid_o}, 32'd0);
    chk("arst_opc", {24'd0, bus.instr_opcode_o}, 32'd0);
    chk("arst_ipc", {20'd0, bus.instr_pc_o}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_req("arst_restart", 12'h000);
    chk("arst_valid2", {31'd0, bus.instr_valid_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
